// File: rtl/bexkat1Def.sv
// Shared types for the bexkat1 memory stage: operation, size, fault cause and FSM state.
package bexkat1Def;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_PUSH  = 3'd2,
        OP_POP   = 3'd3,
        OP_JSR   = 3'd4,
        OP_RTS   = 3'd5,
        OP_EXC   = 3'd6
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_WORD  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_BYTE  = 2'd2,
        SZ_DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_BUSERR   = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } mem_cause_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } mem_state_t;

    function automatic logic [3:0] size_bytes(input mem_size_t size);
        case (size)
            SZ_WORD: return 4'd4;
            SZ_HALF: return 4'd2;
            SZ_BYTE: return 4'd1;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: lane 0 is the MSB lane. Produces the byte select,
// the store data replicated across lanes, and the right-aligned, extended load data.
module mem_lane_align
    import bexkat1Def::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned LANE_W = $clog2(DATA_W / 8)
) (
    input  mem_size_t             i_size,
    input  logic [LANE_W-1:0]     i_adr,
    input  logic                  i_signed,
    input  logic [DATA_W-1:0]     i_st_dat,
    input  logic [DATA_W-1:0]     i_ld_dat,
    output logic [DATA_W/8-1:0]   o_sel,
    output logic [DATA_W-1:0]     o_st_dat,
    output logic [DATA_W-1:0]     o_ld_dat
);

    localparam int unsigned NB = DATA_W / 8;

    int unsigned         w_nb;
    int unsigned         w_idx;
    int unsigned         w_shift;
    logic [NB-1:0]       w_sel_base;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_top;
    logic [DATA_W-1:0]   w_shifted;

    always_comb begin
        w_nb = 32'(size_bytes(i_size));
        if (w_nb > NB) begin
            w_nb = NB;
        end
        w_idx   = 32'(i_adr);
        // Distance in lanes from the last addressed lane to the LSB lane.
        w_shift = NB - w_idx - w_nb;

        w_sel_base = ~({NB{1'b1}} << w_nb);
        o_sel      = w_sel_base << w_shift;

        w_mask    = ~({DATA_W{1'b1}} << (8 * w_nb));
        w_top     = w_mask & ~(w_mask >> 1);
        w_shifted = i_ld_dat >> (8 * w_shift);
        o_ld_dat  = w_shifted & w_mask;
        if (i_signed && |(w_shifted & w_top)) begin
            o_ld_dat = o_ld_dat | ~w_mask;
        end

        o_st_dat = '0;
        for (int i = 0; i < NB; i++) begin
            o_st_dat[DATA_W-1-8*i -: 8] = i_st_dat[8*((w_nb-1) - (i % w_nb)) +: 8];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs one load/store/stack/jump operation at a time on a pipelined Wishbone
// master. Define BEXKAT_MEM_TIMEOUT_EN to abort bus cycles after TIMEOUT_CYC cycles.
module mem_access_unit
    import bexkat1Def::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_op_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [ADDR_W-1:0]     req_adr_i,
    input  logic [DATA_W-1:0]     req_dat_i,
    input  logic [ADDR_W-1:0]     req_tgt_i,
    output logic                  resp_valid_o,
    output logic [DATA_W-1:0]     resp_dat_o,
    output logic                  resp_err_o,
    output logic [1:0]            resp_cause_o,
    output logic                  pc_set_o,
    output logic [ADDR_W-1:0]     pc_o,
    output logic [ADDR_W-1:0]     bus_adr_o,
    output logic                  bus_we_o,
    output logic                  bus_cyc_o,
    output logic                  bus_stb_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [DATA_W-1:0]     bus_dat_o,
    input  logic [DATA_W-1:0]     bus_dat_i,
    input  logic                  bus_ack_i,
    input  logic                  bus_err_i
);

    localparam int unsigned LANE_W = $clog2(DATA_W / 8);

    mem_state_t            r_state, w_state_next;
    mem_cause_t            r_cause, w_cause_next;
    mem_op_t               r_op;
    mem_size_t             r_size;
    logic                  r_signed;
    logic [LANE_W-1:0]     r_lane;
    logic [ADDR_W-1:0]     r_tgt;
    logic [DATA_W-1:0]     r_rdat;
    logic                  r_stb;
    logic [ADDR_W-1:0]     r_bus_adr;
    logic                  r_bus_we;
    logic [DATA_W/8-1:0]   r_bus_sel;
    logic [DATA_W-1:0]     r_bus_dat;

    mem_op_t               w_req_op;
    mem_size_t             w_req_size;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_req_we;
    logic                  w_is_read;
    logic                  w_timeout;
    logic                  w_ok;
    mem_size_t             w_al_size;
    logic [LANE_W-1:0]     w_al_lane;
    logic                  w_al_signed;
    logic [DATA_W/8-1:0]   w_sel;
    logic [DATA_W-1:0]     w_st_dat;
    logic [DATA_W-1:0]     w_ld_dat;

    assign w_req_op  = mem_op_t'(req_op_i);
    assign w_accept  = (r_state == S_IDLE) && req_valid_i;
    assign w_req_we  = w_req_op inside {OP_STORE, OP_PUSH, OP_JSR, OP_EXC};
    assign w_is_read = r_op inside {OP_LOAD, OP_POP, OP_RTS};

    // Only LOAD/STORE carry a size; stack and control-flow operations move one word.
    always_comb begin
        w_req_size = (w_req_op == OP_LOAD || w_req_op == OP_STORE) ?
                     mem_size_t'(req_size_i) : SZ_WORD;
        case (w_req_size)
            SZ_HALF:  w_misalign = req_adr_i[0];
            SZ_WORD:  w_misalign = |req_adr_i[1:0];
            SZ_DWORD: w_misalign = (DATA_W == 32) || (|req_adr_i[2:0]);
            default:  w_misalign = 1'b0;
        endcase
    end

    // Steer the aligner from the live request when accepting, from captured state otherwise.
    assign w_al_size   = (r_state == S_IDLE) ? w_req_size : r_size;
    assign w_al_lane   = (r_state == S_IDLE) ? req_adr_i[LANE_W-1:0] : r_lane;
    assign w_al_signed = (r_state == S_IDLE) ? req_signed_i : r_signed;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .i_size   (w_al_size),
        .i_adr    (w_al_lane),
        .i_signed (w_al_signed),
        .i_st_dat (req_dat_i),
        .i_ld_dat (bus_dat_i),
        .o_sel    (w_sel),
        .o_st_dat (w_st_dat),
        .o_ld_dat (w_ld_dat)
    );

`ifdef BEXKAT_MEM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_BUS) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == S_BUS) && (r_tmo_cnt == TMO_LAST);
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = TIMEOUT_CYC;
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_state_next = w_misalign ? S_DONE : S_BUS;
                    w_cause_next = w_misalign ? CAUSE_MISALIGN : CAUSE_NONE;
                end
            end
            S_BUS: begin
                if (bus_err_i) begin
                    w_state_next = S_DONE;
                    w_cause_next = CAUSE_BUSERR;
                end else if (bus_ack_i) begin
                    w_state_next = S_DONE;
                    w_cause_next = CAUSE_NONE;
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op      <= OP_LOAD;
            r_size    <= SZ_WORD;
            r_signed  <= 1'b0;
            r_lane    <= '0;
            r_tgt     <= '0;
            r_rdat    <= '0;
            r_stb     <= 1'b0;
            r_bus_adr <= '0;
            r_bus_we  <= 1'b0;
            r_bus_sel <= '0;
            r_bus_dat <= '0;
        end else begin
            r_stb <= w_accept && !w_misalign;
            if (w_accept) begin
                r_op     <= w_req_op;
                r_size   <= w_req_size;
                r_signed <= req_signed_i;
                r_lane   <= req_adr_i[LANE_W-1:0];
                r_tgt    <= req_tgt_i;
                r_rdat   <= '0;
                if (!w_misalign) begin
                    r_bus_adr <= req_adr_i;
                    r_bus_we  <= w_req_we;
                    r_bus_sel <= w_sel;
                    r_bus_dat <= w_req_we ? w_st_dat : '0;
                end
            end else if (r_state == S_BUS && bus_ack_i && !bus_err_i && w_is_read) begin
                r_rdat <= w_ld_dat;
            end
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign bus_cyc_o   = (r_state == S_BUS);
    assign bus_stb_o   = r_stb;
    assign bus_adr_o   = r_bus_adr;
    assign bus_we_o    = r_bus_we;
    assign bus_sel_o   = r_bus_sel;
    assign bus_dat_o   = r_bus_dat;

    // RTS redirects to the low ADDR_W bits of the popped word; assumes ADDR_W <= DATA_W.
    always_comb begin
        resp_valid_o = (r_state == S_DONE);
        w_ok         = resp_valid_o && (r_cause == CAUSE_NONE);
        resp_err_o   = resp_valid_o && (r_cause != CAUSE_NONE);
        resp_cause_o = resp_valid_o ? r_cause : CAUSE_NONE;
        resp_dat_o   = w_ok ? r_rdat : '0;
        pc_set_o     = w_ok && (r_op inside {OP_JSR, OP_EXC, OP_RTS});
        pc_o         = '0;
        if (pc_set_o) begin
            pc_o = (r_op == OP_RTS) ? r_rdat[ADDR_W-1:0] : r_tgt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a byte-level big-endian memory-stage model.
module tb_mem_access_unit;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned NB  = DW / 8;
    localparam int unsigned TMO = 8;

    localparam int LOAD = 0, STORE = 1, PUSH = 2, POP = 3, JSR = 4, RTS = 5, EXC = 6;
    localparam int SZ_WORD = 0, SZ_HALF = 1, SZ_BYTE = 2, SZ_DWORD = 3;
    localparam int C_NONE = 0, C_MIS = 1, C_BUS = 2, C_TMO = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      req_op_i;
    logic [1:0]      req_size_i;
    logic            req_signed_i;
    logic [AW-1:0]   req_adr_i;
    logic [DW-1:0]   req_dat_i;
    logic [AW-1:0]   req_tgt_i;
    logic            resp_valid_o;
    logic [DW-1:0]   resp_dat_o;
    logic            resp_err_o;
    logic [1:0]      resp_cause_o;
    logic            pc_set_o;
    logic [AW-1:0]   pc_o;
    logic [AW-1:0]   bus_adr_o;
    logic            bus_we_o;
    logic            bus_cyc_o;
    logic            bus_stb_o;
    logic [NB-1:0]   bus_sel_o;
    logic [DW-1:0]   bus_dat_o;
    logic [DW-1:0]   bus_dat_i;
    logic            bus_ack_i;
    logic            bus_err_i;

    mem_access_unit #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_adr_i    (req_adr_i),
        .req_dat_i    (req_dat_i),
        .req_tgt_i    (req_tgt_i),
        .resp_valid_o (resp_valid_o),
        .resp_dat_o   (resp_dat_o),
        .resp_err_o   (resp_err_o),
        .resp_cause_o (resp_cause_o),
        .pc_set_o     (pc_set_o),
        .pc_o         (pc_o),
        .bus_adr_o    (bus_adr_o),
        .bus_we_o     (bus_we_o),
        .bus_cyc_o    (bus_cyc_o),
        .bus_stb_o    (bus_stb_o),
        .bus_sel_o    (bus_sel_o),
        .bus_dat_o    (bus_dat_o),
        .bus_dat_i    (bus_dat_i),
        .bus_ack_i    (bus_ack_i),
        .bus_err_i    (bus_err_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input int sz);
        case (sz)
            SZ_WORD: return 4;
            SZ_HALF: return 2;
            SZ_BYTE: return 1;
            default: return 8;
        endcase
    endfunction

    function automatic bit misaligned(input int sz, input logic [AW-1:0] adr);
        case (sz)
            SZ_WORD: return (adr % 4) != 0;
            SZ_HALF: return (adr % 2) != 0;
            SZ_BYTE: return 1'b0;
            default: return (DW == 32) || ((adr % 8) != 0);
        endcase
    endfunction

    function automatic logic [NB-1:0] m_sel(input int sz, input logic [AW-1:0] adr);
        logic [NB-1:0] s = '0;
        int idx = int'(adr % NB);
        for (int j = idx; j < idx + nbytes(sz); j++) s[NB-1-j] = 1'b1;
        return s;
    endfunction

    function automatic logic [DW-1:0] m_wdata(input int sz, input logic [DW-1:0] dat);
        int nb = nbytes(sz);
        logic [DW-1:0] w = '0;
        logic [DW-1:0] m = (nb * 8 >= DW) ? '1 : ((DW'(1) << (nb * 8)) - DW'(1));
        for (int r = 0; r < int'(NB) / nb; r++) w = (w << (8 * nb)) | (dat & m);
        return w;
    endfunction

    // Concatenate the addressed bytes in address order, then extend.
    function automatic logic [DW-1:0] m_load(input int sz, input bit sgn, input logic [AW-1:0] adr,
                                             input logic [DW-1:0] rdata);
        int nb = nbytes(sz);
        int idx = int'(adr % NB);
        logic [DW-1:0] v = '0;
        for (int j = 0; j < nb; j++) v = (v << 8) | DW'(rdata[DW-1-8*(idx+j) -: 8]);
        if (sgn && v[8*nb-1]) for (int b = 8 * nb; b < int'(DW); b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic drive_req(input int op, input int sz, input bit sgn, input logic [AW-1:0] adr,
                             input logic [DW-1:0] dat, input logic [AW-1:0] tgt);
        req_op_i     = 3'(op);
        req_size_i   = 2'(sz);
        req_signed_i = sgn;
        req_adr_i    = adr;
        req_dat_i    = dat;
        req_tgt_i    = tgt;
        req_valid_i  = 1'b1;
        check("req_ready", req_ready_o, 1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic run_op(input int op, input int sz, input bit sgn, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [AW-1:0] tgt,
                          input logic [DW-1:0] rdata, input int lat, input bit berr,
                          input bit both);
        int es;
        bit we, rd, redir;
        logic [DW-1:0] ld;
        es = (op == LOAD || op == STORE) ? sz : SZ_WORD;
        we = op inside {STORE, PUSH, JSR, EXC};
        rd = op inside {LOAD, POP, RTS};
        drive_req(op, sz, sgn, adr, dat, tgt);
        if (misaligned(es, adr)) begin
            check("mis_valid", resp_valid_o, 1);
            check("mis_err", resp_err_o, 1);
            check("mis_cause", resp_cause_o, C_MIS);
            check("mis_cyc", bus_cyc_o, 0);
            check("mis_stb", bus_stb_o, 0);
            check("mis_pcset", pc_set_o, 0);
            check("mis_dat", resp_dat_o, 0);
        end else begin
            ld = m_load(es, sgn, adr, rdata);
            check("cyc", bus_cyc_o, 1);
            check("stb", bus_stb_o, 1);
            check("adr", bus_adr_o, adr);
            check("we", bus_we_o, we);
            check("sel", bus_sel_o, m_sel(es, adr));
            if (we) check("wdat", bus_dat_o, m_wdata(es, dat));
            for (int c = 1; c < lat; c++) begin
                @(posedge clk_i); #1;
                check("stb_once", bus_stb_o, 0);
                check("cyc_hold", bus_cyc_o, 1);
                check("no_early_resp", resp_valid_o, 0);
            end
            bus_dat_i = rdata;
            bus_ack_i = !berr || both;
            bus_err_i = berr;
            @(posedge clk_i); #1;
            bus_ack_i = 1'b0;
            bus_err_i = 1'b0;
            bus_dat_i = DW'($urandom);
            check("resp_valid", resp_valid_o, 1);
            check("cyc_drop", bus_cyc_o, 0);
            check("resp_err", resp_err_o, berr);
            check("resp_cause", resp_cause_o, berr ? C_BUS : C_NONE);
            redir = !berr && (op inside {JSR, EXC, RTS});
            check("pc_set", pc_set_o, redir);
            if (redir) check("pc", pc_o, (op == RTS) ? ld[AW-1:0] : tgt);
            if (rd || berr) check("resp_dat", resp_dat_o, berr ? '0 : ld);
        end
        @(posedge clk_i); #1;
        check("resp_pulse", resp_valid_o, 0);
        check("ready_back", req_ready_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int op, sz, lat;
        logic [AW-1:0] adr;

        rst_i = 1'b0;
        req_valid_i = 1'b0;
        req_op_i = '0;
        req_size_i = '0;
        req_signed_i = 1'b0;
        req_adr_i = '0;
        req_dat_i = '0;
        req_tgt_i = '0;
        bus_dat_i = '0;
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;

        #2 rst_i = 1'b1;
        #1;
        check("rst_cyc", bus_cyc_o, 0);
        check("rst_stb", bus_stb_o, 0);
        check("rst_resp", resp_valid_o, 0);
        check("rst_pcset", pc_set_o, 0);
        check("rst_sel", bus_sel_o, 0);
        check("rst_we", bus_we_o, 0);
        check("rst_ready", req_ready_o, 1);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_op(LOAD, SZ_BYTE, 1, 32'h1001, '0, '0, DW'(32'h12F45678), 2, 0, 0);
        run_op(STORE, SZ_HALF, 0, 32'h2006, DW'(16'hBEEF), '0, '0, 1, 0, 0);
        run_op(LOAD, SZ_WORD, 0, 32'h3002, '0, '0, '0, 1, 0, 0);
        run_op(RTS, SZ_BYTE, 0, 32'h0100, '0, '0, DW'(32'h00004000), 3, 0, 0);
        run_op(RTS, SZ_WORD, 0, 32'h0100, '0, '0, DW'(32'h00004000), 2, 1, 0);
        run_op(JSR, SZ_WORD, 0, 32'h0FFC, DW'(32'h00001234), 32'h0000_8000, '0, 1, 0, 0);
        run_op(EXC, SZ_WORD, 0, 32'h0FF8, DW'(32'h00002000), 32'h0000_0010, '0, 2, 1, 1);
        run_op(POP, SZ_HALF, 1, 32'h0FF8, '0, '0, DW'(32'h8000_0001), 1, 0, 0);
        run_op(LOAD, SZ_HALF, 1, 32'h0002, '0, '0, DW'(32'h1234_8001), 1, 0, 0);
        run_op(LOAD, SZ_HALF, 0, 32'h0003, '0, '0, '0, 1, 0, 0);

        for (int i = 0; i < 300; i++) begin
            op  = $urandom_range(0, 6);
            sz  = $urandom_range(0, (DW == 64) ? 3 : 2);
            adr = $urandom;
            if ($urandom_range(0, 1) == 1) adr[2:0] = 3'b000;
            lat = $urandom_range(1, 6);
            run_op(op, sz, 1'($urandom), adr, DW'({$urandom, $urandom}), $urandom,
                   DW'({$urandom, $urandom}), lat, $urandom_range(0, 4) == 0, 1'($urandom));
        end

        // Bus slave never answers.
        drive_req(LOAD, SZ_WORD, 0, 32'h5000, '0, '0);
`ifdef BEXKAT_MEM_TIMEOUT_EN
        n = 0;
        while (bus_cyc_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_valid", resp_valid_o, 1);
        check("tmo_cause", resp_cause_o, C_TMO);
        check("tmo_err", resp_err_o, 1);
        bus_ack_i = 1'b1;
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0;
        check("late_ack_ignored", resp_valid_o, 0);
        @(posedge clk_i); #1;
        check("late_ack_quiet", resp_valid_o, 0);
        check("late_ack_cyc", bus_cyc_o, 0);
`else
        n = 0;
        repeat (20) begin
            if (bus_cyc_o !== 1'b1 || resp_valid_o !== 1'b0) n++;
            @(posedge clk_i); #1;
        end
        check("wait_forever", n, 0);
        bus_ack_i = 1'b1;
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0;
        check("slow_ack_valid", resp_valid_o, 1);
        check("slow_ack_cause", resp_cause_o, C_NONE);
        @(posedge clk_i); #1;
`endif

        // Reset in the middle of a bus cycle.
        drive_req(STORE, SZ_WORD, 0, 32'h6000, DW'(32'hCAFE_F00D), '0);
        @(posedge clk_i); #1;
        check("pre_rst_cyc", bus_cyc_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_cyc", bus_cyc_o, 0);
        check("mid_rst_stb", bus_stb_o, 0);
        check("mid_rst_we", bus_we_o, 0);
        check("mid_rst_adr", bus_adr_o, 0);
        check("mid_rst_dat", bus_dat_o, 0);
        check("mid_rst_resp", resp_valid_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        bus_ack_i = 1'b1;
        n = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            bus_ack_i = 1'b0;
            if (resp_valid_o !== 1'b0) n++;
        end
        check("post_rst_no_resp", n, 0);
        run_op(LOAD, SZ_BYTE, 0, 32'h6003, '0, '0, DW'(32'hAABBCCDD), 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the bexkat1 pipeline memory stage. Sequences one memory operation at a time onto a pipelined Wishbone master port.
- Supported operations: load, store, push, pop, jsr, rts, exception-entry.
- Generalised to DATA_W of 32 or 64. Adds right-aligned, sign-extending sub-word loads, misalignment detection, and bus-error reporting. An optional bus timeout is compiled in by macro.
- Sits between execute and writeback. Upstream issues requests on a valid/ready handshake; the unit returns a single-cycle response pulse.

Parameters:
- DATA_W, 32, bus/register data width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYC, 255, cycles from strobe to abort; used only when BEXKAT_MEM_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request
- req_op_i  in  3  mem_op_t: LOAD=0, STORE=1, PUSH=2, POP=3, JSR=4, RTS=5, EXC=6
- req_size_i  in  2  mem_size_t: WORD=0 (32b), HALF=1, BYTE=2, DWORD=3 (legal only when DATA_W=64)
- req_signed_i  in  1  sign-extend sub-word load
- req_adr_i  in  ADDR_W  effective byte address
- req_dat_i  in  DATA_W  store / push / return-PC data, right-aligned
- req_tgt_i  in  ADDR_W  branch target for JSR/EXC
- resp_valid_o  out  1  one-cycle response pulse
- resp_dat_o  out  DATA_W  load/pop result, right-aligned
- resp_err_o  out  1  operation faulted
- resp_cause_o  out  2  mem_cause_t: NONE=0, MISALIGN=1, BUSERR=2, TIMEOUT=3
- pc_set_o  out  1  pulse with resp_valid_o; redirect fetch
- pc_o  out  ADDR_W  redirect target
- bus_adr_o  out  ADDR_W
- bus_we_o  out  1
- bus_cyc_o  out  1
- bus_stb_o  out  1
- bus_sel_o  out  DATA_W/8
- bus_dat_o  out  DATA_W
- bus_dat_i  in  DATA_W
- bus_ack_i  in  1
- bus_err_i  in  1

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i. On reset every registered output is 0 and the state is S_IDLE. Asserting reset mid-transfer drops bus_cyc_o immediately and issues no response.
- States and transitions:
  - S_IDLE: req_ready_o=1. When req_valid_i is high, the request is accepted and captured into registers.
    - If misaligned (HALF with adr[0]=1; WORD with adr[1:0]!=0; DWORD with adr[2:0]!=0): go to S_DONE with cause MISALIGN; no bus cycle.
    - Otherwise go to S_BUS. Next cycle: bus_cyc_o=1, bus_stb_o=1.
  - S_BUS: bus_stb_o is high for exactly one cycle; bus_cyc_o stays high until termination.
    - bus_ack_i: go to S_DONE, cause NONE.
    - bus_err_i: go to S_DONE, cause BUSERR.
    - If ack and err arrive together, err wins.
  - S_DONE: resp_valid_o=1 for one cycle, bus_cyc_o=0, req_ready_o=0. Always returns to S_IDLE.
- Latency: accept at cycle 0, stb at cycle 1, ack at cycle k, resp_valid_o at k+1. A misaligned request responds at cycle 1.
- req_ready_o is combinational and equals (state==S_IDLE).
- bus_we_o=1 for STORE, PUSH, JSR and EXC.
- Lanes are big-endian: the lowest address maps to the MSB lane.
  - Byte-lane index = addr[log2(DATA_W/8)-1:0] counted from the MSB.
  - Store data is replicated across all lanes of its size; bus_sel_o is set for the addressed lanes only.
  - PUSH, POP, JSR, RTS and EXC are always WORD-sized.
- Load and pop data: selected lanes are shifted to bit 0. If req_signed_i, the result is sign-extended to DATA_W; otherwise it is zero-extended.
- Redirect:
  - JSR and EXC with no error: pc_set_o=1, pc_o=req_tgt_i.
  - RTS with no error: pc_set_o=1, pc_o=loaded word[ADDR_W-1:0].
- On any error: pc_set_o=0 and resp_dat_o=0.

Optional Feature:
- BEXKAT_MEM_TIMEOUT_EN defined: a 16-bit counter clears when stb is issued and increments each S_BUS cycle. On reaching TIMEOUT_CYC with no ack/err: drop bus_cyc_o, go to S_DONE, cause TIMEOUT. A late ack is ignored.
- BEXKAT_MEM_TIMEOUT_EN undefined: no counter exists; S_BUS waits indefinitely, and cause TIMEOUT is never produced.

Decomposition:
- Package bexkat1Def holds mem_op_t, mem_size_t, mem_cause_t and the state enum.
- One sub-module, mem_lane_align: purely combinational.
  - Inputs: size, addr, signed.
  - Outputs: bus_sel, store replication, load extraction/extension.
  - Parametrised by DATA_W.

Test Plan:
- DATA_W=32, LOAD BYTE signed at adr 0x1001, bus returns 0x12F45678 -> bus_sel_o=0100, resp_dat_o=0xFFFFFFF4, cause NONE.
- DATA_W=64, STORE HALF at adr 0x2006, dat 0xBEEF -> bus_sel_o=0x03, bus_dat_o=0xBEEFBEEFBEEFBEEF, bus_we_o=1; resp one cycle after ack.
- LOAD WORD at adr 0x3002 -> bus_cyc_o never asserts; resp_valid_o at cycle 1, resp_err_o=1, cause MISALIGN.
- RTS, bus returns 0x00004000 -> pc_set_o=1, pc_o=0x4000 on the resp_valid_o cycle. Repeat with bus_err_i -> pc_set_o=0, cause BUSERR.
- With BEXKAT_MEM_TIMEOUT_EN and TIMEOUT_CYC=8, no ack -> cyc drops after 8 S_BUS cycles, cause TIMEOUT. A later ack produces no extra response.
- Assert rst_i during S_BUS -> all outputs 0 asynchronously; the next request after reset completes normally.
